// File: rtl/fp16_pkg.sv
// Shared half-precision constants and the divider FSM encoding.
// Used by the fp16 multiplier and divider so both agree on field layout.
package fp16_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam logic [14:0] FP16_INF = 15'h7C00;

    // significand width including the hidden bit
    localparam int FP16_SIG_W = FP16_MAN_W + 1;
    localparam int DIV_ITERS  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } fp16_state_e;

endpackage

// File: rtl/fp16_divider_seq_if.sv
// Handshake and operand/result bundle of the sequential fp16 divider.
//   start        request, sampled only while the divider is idle
//   A, B         dividend and divisor {sign, exp[4:0], man[9:0]}
//   busy, done   operation in flight / one-cycle completion pulse
//   out, dz, ovf quotient and flags, held until the next done
interface fp16_divider_seq_if;

    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        dz;
    logic        ovf;

    modport master (
        output start, A, B,
        input  busy, done, out, dz, ovf
    );

    modport slave (
        input  start, A, B,
        output busy, done, out, dz, ovf
    );

endinterface

// File: rtl/fp16_div_step.sv
// One restoring-division step, purely combinational.
//   rem       partial remainder (13b)
//   divisor   11-bit significand including hidden bit
//   rem_next  (rem - divisor) << 1 when rem >= divisor, else rem << 1
//   qbit      quotient bit, 1 when rem >= divisor
// The subtract is a ripple-carry add of rem + ~divisor + 1; its carry out
// doubles as the rem >= divisor compare, so no separate comparator exists.
module fp16_div_step
    import fp16_pkg::*;
(
    input  logic [12:0]           rem,
    input  logic [FP16_SIG_W-1:0] divisor,
    output logic [12:0]           rem_next,
    output logic                  qbit
);

    logic [12:0] sub_b;
    logic [13:0] carry;
    logic [11:0] diff;

    assign sub_b    = ~{2'b00, divisor};
    assign carry[0] = 1'b1;

    // The top sum bit is never kept: a successful subtract leaves a value
    // below the divisor, so only its carry is needed.
    for (genvar i = 0; i < 13; i++) begin : g_rca
        assign carry[i+1] = (rem[i] & sub_b[i]) | (carry[i] & (rem[i] ^ sub_b[i]));
        if (i < 12) begin : g_sum
            assign diff[i] = rem[i] ^ sub_b[i] ^ carry[i];
        end
    end

    assign qbit     = carry[13];
    assign rem_next = qbit ? {diff, 1'b0} : {rem[11:0], 1'b0};

endmodule

// File: rtl/fp16_divider_seq.sv
// Sequential IEEE-754 half-precision divider, out = A / B.
// Normal operands only, truncating mantissa, no denormals; exp=31 inputs are
// treated as ordinary exponents. One quotient bit per cycle, fixed latency of
// 14 cycles from the accept cycle to done.
//   CLK      clock, rising edge
//   RESETn   asynchronous active-low reset, aborts any operation in flight
//   bus      slave side of fp16_divider_seq_if (start/A/B in, busy/done/out/dz/ovf out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on the accept edge
// ST_DIV  | 12 restoring steps, iter_cnt 0..11
// ST_NORM | normalise quotient, apply exceptions, register result + done
// ST_DONE | done pulse cycle; start is ignored here
module fp16_divider_seq
    import fp16_pkg::*;
(
    input  logic               CLK,
    input  logic               RESETn,
    fp16_divider_seq_if.slave  bus
);

    fp16_state_e           state;
    logic [3:0]            iter_cnt;
    logic                  sign_q;
    logic                  a_zero_q;
    logic                  b_zero_q;
    logic signed [6:0]     eq_q;
    logic [FP16_SIG_W-1:0] mb_q;
    logic [12:0]           rem_q;
    logic [11:0]           quo_q;

    logic [12:0]           rem_next;
    logic                  qbit;

    logic [FP16_EXP_W-1:0] ea;
    logic [FP16_EXP_W-1:0] eb;
    logic signed [6:0]     eq_calc;

    logic signed [6:0]     exp_norm;
    logic [FP16_MAN_W-1:0] man_norm;
    logic [15:0]           res;
    logic                  res_dz;
    logic                  res_ovf;

    assign ea = bus.A[FP16_MAN_W +: FP16_EXP_W];
    assign eb = bus.B[FP16_MAN_W +: FP16_EXP_W];

    // 7-bit two's complement covers the full -16..46 range of ea - eb + bias.
    assign eq_calc = 7'(ea) - 7'(eb) + 7'(FP16_BIAS);

    fp16_div_step u_step (
        .rem      (rem_q),
        .divisor  (mb_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Quotient lies in (2^10, 2^12): either the top bit is the hidden one,
    // or the next bit is and the exponent drops by one.
    always_comb begin
        exp_norm = quo_q[11] ? eq_q : eq_q - 7'sd1;
        man_norm = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
        res      = {sign_q, 15'h0000};
        res_dz   = 1'b0;
        res_ovf  = 1'b0;
        if (b_zero_q) begin
            res    = {sign_q, FP16_INF};
            res_dz = 1'b1;
        end else if (a_zero_q) begin
            res = {sign_q, 15'h0000};
        end else if (exp_norm >= 7'sd31) begin
            res     = {sign_q, FP16_INF};
            res_ovf = 1'b1;
        end else if (exp_norm <= 7'sd0) begin
            res = {sign_q, 15'h0000};
        end else begin
            res = {sign_q, exp_norm[4:0], man_norm};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            iter_cnt <= '0;
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            eq_q     <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.out  <= 16'h0000;
            bus.dz   <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sign_q   <= bus.A[15] ^ bus.B[15];
                        a_zero_q <= (ea == '0);
                        b_zero_q <= (eb == '0);
                        eq_q     <= eq_calc;
                        mb_q     <= {1'b1, bus.B[FP16_MAN_W-1:0]};
                        rem_q    <= {2'b00, 1'b1, bus.A[FP16_MAN_W-1:0]};
                        quo_q    <= '0;
                        iter_cnt <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem_q    <= rem_next;
                    quo_q    <= {quo_q[10:0], qbit};
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == 4'(DIV_ITERS - 1)) begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    bus.out  <= res;
                    bus.dz   <= res_dz;
                    bus.ovf  <= res_ovf;
                    bus.done <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_divider_seq.sv
module tb_fp16_divider_seq;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;

    fp16_divider_seq_if bus ();

    fp16_divider_seq dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, then measure latency and check the result.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic exp_dz, input logic exp_ovf);
        int lat;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge CLK);
        bus.start = 1'b0;
        check({name, "_busy_t1"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd14);
        check({name, "_out"}, 32'(bus.out), 32'(exp_out));
        check({name, "_dz"}, 32'(bus.dz), 32'(exp_dz));
        check({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({name, "_busy_done"}, 32'(bus.busy), 32'd1);
        @(negedge CLK);
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n_done;
        int first_done;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;

        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out",  32'(bus.out),  32'd0);
        check("rst_dz",   32'(bus.dz),   32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        run_op("one_div_one", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0);
        run_op("six_div_two", 16'h4600, 16'h4000, 16'h4200, 1'b0, 1'b0);
        run_op("neg_two_half", 16'hC000, 16'h3800, 16'hC400, 1'b0, 1'b0);
        run_op("one_third", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0);
        run_op("div_zero", 16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1'b0);
        run_op("zero_zero", 16'h0000, 16'h0000, 16'h7C00, 1'b1, 1'b0);
        run_op("overflow", 16'h7800, 16'h0400, 16'h7C00, 1'b0, 1'b1);
        run_op("ovf_exp31", 16'h7800, 16'h3800, 16'h7C00, 1'b0, 1'b1);
        run_op("max_exp30", 16'h7800, 16'h3C00, 16'h7800, 1'b0, 1'b0);
        run_op("underflow", 16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b0);
        run_op("min_exp1", 16'h0400, 16'h3C00, 16'h0400, 1'b0, 1'b0);
        run_op("flush_exp0", 16'h0400, 16'h3E00, 16'h0000, 1'b0, 1'b0);
        run_op("neg_zero_a", 16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0);

        // Stray starts mid-operation and in the done cycle, then back-to-back.
        @(negedge CLK);
        bus.start = 1'b1;
        bus.A     = 16'h4600;
        bus.B     = 16'h4000;
        @(negedge CLK);
        bus.start  = 1'b0;
        n_done     = 0;
        first_done = 0;
        for (int n = 1; n <= 35; n++) begin
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = n;
                    check("b2b_first_out", 32'(bus.out), 32'h4200);
                end else if (n_done == 2) begin
                    check("b2b_second_at", 32'(n), 32'd29);
                    check("b2b_second_out", 32'(bus.out), 32'h3555);
                end
            end
            if (n == 5) begin
                bus.start = 1'b1;
                bus.A     = 16'h3C00;
                bus.B     = 16'h3C00;
            end else if (n == 6) begin
                bus.start = 1'b0;
            end else if (n == 14) begin
                bus.start = 1'b1;
                bus.A     = 16'h3C00;
                bus.B     = 16'h4200;
            end else if (n == 16) begin
                bus.start = 1'b0;
                check("b2b_busy_second", 32'(bus.busy), 32'd1);
            end else if (n == 20) begin
                check("b2b_out_hold", 32'(bus.out), 32'h4200);
            end
            @(negedge CLK);
        end
        check("b2b_first_at", 32'(first_done), 32'd14);
        check("b2b_done_count", 32'(n_done), 32'd2);

        // Abort by reset at T+7; the previous result (3555) must clear at once.
        @(negedge CLK);
        bus.start = 1'b1;
        bus.A     = 16'h3C00;
        bus.B     = 16'h3C00;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (6) @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_out",  32'(bus.out),  32'd0);
        check("abort_dz",   32'(bus.dz),   32'd0);
        check("abort_ovf",  32'(bus.ovf),  32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        n_done = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge CLK);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op("after_abort", 16'h4600, 16'h4000, 16'h4200, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
